// File: rtl/tick_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tick_mon_pkg
// Description : Shared state encoding and in-range check for the tick period
//               monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package tick_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_FAULT   = 2'd3
    } tick_mon_state_t;

    // Written as value+tol >= exp so a tolerance wider than the period cannot underflow.
    function automatic logic in_range(input int unsigned value,
                                      input int unsigned exp_period,
                                      input int unsigned tol);
        return ((value + tol) >= exp_period) && (value <= (exp_period + tol));
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_interval_counter.sv
`default_nettype none
// ============================================================================
// Module      : tick_interval_counter
// Description : Saturating cycles-since-tick counter with registered period
//               capture.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_interval_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             capture,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] period,
    output logic             period_valid
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt          <= '0;
            period       <= '0;
            period_valid <= 1'b0;
        end else begin
            period_valid <= capture;
            if (capture) begin
                period <= cnt;
            end
            if (tick) begin
                cnt <= CNT_W'(1);
            end else if (cnt != c_CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tick_period_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tick_period_monitor
// Description : Measures the interval between tick pulses, locks onto a stable
//               in-range stream and flags out-of-range or overdue ticks.
//               Optional statistics outputs under TICK_MON_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_period_monitor
    import tick_mon_pkg::*;
#(
    parameter int INTERNAL_CLK     = 4,
    parameter int OUTPUT_TIME_FREQ = 1,
    parameter int EXP_PERIOD       = INTERNAL_CLK / OUTPUT_TIME_FREQ,
    parameter int TOL              = 0,
    parameter int LOCK_COUNT       = 2,
    parameter int CNT_W            = $clog2(EXP_PERIOD + TOL + 2)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             fault,
    output logic             timeout
`ifdef TICK_MON_STATS_EN
    ,
    output logic [CNT_W-1:0] min_period,
    output logic [CNT_W-1:0] max_period,
    output logic [7:0]       err_cnt
`endif
);

    localparam int               c_GOOD_W      = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] c_TIMEOUT_CNT = CNT_W'(EXP_PERIOD + TOL + 1);

    tick_mon_state_t     r_state;
    logic [c_GOOD_W-1:0] r_good;
    logic [c_GOOD_W-1:0] w_good_inc;
    logic [CNT_W-1:0]    w_cnt;
    logic                w_capture;
    logic                w_in_range;
    logic                w_active;
    logic                w_bad_period;
    logic                w_timeout_hit;
    logic                w_enter_fault;

    assign w_capture     = tick && (r_state != ST_IDLE);
    assign w_in_range    = in_range(32'(w_cnt), EXP_PERIOD, TOL);
    assign w_active      = (r_state == ST_MEASURE) || (r_state == ST_LOCKED);
    assign w_bad_period  = w_active && tick && !w_in_range;
    // A tick on the overdue cycle is judged as a bad period, never as a timeout.
    assign w_timeout_hit = w_active && !tick && (w_cnt == c_TIMEOUT_CNT);
    assign w_enter_fault = w_bad_period || w_timeout_hit;
    assign w_good_inc    = r_good + 1'b1;

    tick_interval_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick         (tick),
        .capture      (w_capture),
        .cnt          (w_cnt),
        .period       (period),
        .period_valid (period_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_good  <= '0;
            locked  <= 1'b0;
            fault   <= 1'b0;
            timeout <= 1'b0;
        end else begin
            timeout <= 1'b0;
            if (w_enter_fault) begin
                r_state <= ST_FAULT;
                r_good  <= '0;
                locked  <= 1'b0;
                fault   <= 1'b1;
                timeout <= w_timeout_hit;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (tick) begin
                            r_state <= ST_MEASURE;
                            r_good  <= '0;
                        end
                    end
                    ST_MEASURE: begin
                        if (tick) begin
                            r_good <= w_good_inc;
                            if (32'(w_good_inc) >= LOCK_COUNT) begin
                                r_state <= ST_LOCKED;
                                locked  <= 1'b1;
                            end
                        end
                    end
                    ST_LOCKED: begin
                        r_state <= ST_LOCKED;
                    end
                    ST_FAULT: begin
                        if (tick && w_in_range) begin
                            r_state <= ST_MEASURE;
                            r_good  <= c_GOOD_W'(1);
                            fault   <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef TICK_MON_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            min_period <= '1;
            max_period <= '0;
            err_cnt    <= '0;
        end else begin
            if (w_capture) begin
                if (w_cnt < min_period) min_period <= w_cnt;
                if (w_cnt > max_period) max_period <= w_cnt;
            end
            if (w_enter_fault && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_tick_period_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_tick_period_monitor
// Description : Self-checking bench for tick_period_monitor (EXP_PERIOD=4,
//               TOL=0, LOCK_COUNT=2); stats checks under TICK_MON_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tick_period_monitor;

    localparam int CNT_W = 3;

    typedef struct packed {
        logic             rst_n;
        logic             tick;
        logic             pv;
        logic [CNT_W-1:0] period;
        logic             locked;
        logic             fault;
        logic             timeout;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             tick;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             locked;
    logic             fault;
    logic             timeout;
`ifdef TICK_MON_STATS_EN
    logic [CNT_W-1:0] min_period;
    logic [CNT_W-1:0] max_period;
    logic [7:0]       err_cnt;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs[$];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    tick_period_monitor #(
        .INTERNAL_CLK     (4),
        .OUTPUT_TIME_FREQ (1),
        .EXP_PERIOD       (4),
        .TOL              (0),
        .LOCK_COUNT       (2),
        .CNT_W            (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick         (tick),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .fault        (fault),
        .timeout      (timeout)
`ifdef TICK_MON_STATS_EN
        ,
        .min_period   (min_period),
        .max_period   (max_period),
        .err_cnt      (err_cnt)
`endif
    );

    task automatic add(input logic r, input logic t, input logic pv, input int p,
                       input logic l, input logic f, input logic to);
        vec_t v;
        v.rst_n   = r;
        v.tick    = t;
        v.pv      = pv;
        v.period  = CNT_W'(p);
        v.locked  = l;
        v.fault   = f;
        v.timeout = to;
        vecs.push_back(v);
    endtask

    task automatic quiet(input int n, input int p, input logic l, input logic f);
        for (int i = 0; i < n; i++) add(1'b1, 1'b0, 1'b0, p, l, f, 1'b0);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic t);
        @(negedge clk);
        rst_n = r;
        tick  = t;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        vec_t e;
        int   pulses;
        int   first_at;

        rst_n = 1'b0;
        tick  = 1'b0;

        // rst_n, tick, then expected outputs after that cycle's edge
        add(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);   // first tick: no period
        quiet(3, 0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b1, 4, 1'b0, 1'b0, 1'b0);
        quiet(3, 4, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b1, 4, 1'b1, 1'b0, 1'b0);   // second good period locks
        quiet(3, 4, 1'b1, 1'b0);
        add(1'b1, 1'b1, 1'b1, 4, 1'b1, 1'b0, 1'b0);
        quiet(2, 4, 1'b1, 1'b0);
        add(1'b1, 1'b1, 1'b1, 3, 1'b0, 1'b1, 1'b0);   // short period -> fault
        quiet(3, 3, 1'b0, 1'b1);
        add(1'b1, 1'b1, 1'b1, 4, 1'b0, 1'b0, 1'b0);   // recovery
        quiet(3, 4, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b1, 4, 1'b1, 1'b0, 1'b0);
        quiet(4, 4, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b0, 4, 1'b0, 1'b1, 1'b1);   // overdue tick
        quiet(3, 4, 1'b0, 1'b1);
        add(1'b1, 1'b1, 1'b1, 7, 1'b0, 1'b1, 1'b0);   // saturated count
        quiet(3, 7, 1'b0, 1'b1);
        add(1'b1, 1'b1, 1'b1, 4, 1'b0, 1'b0, 1'b0);
        quiet(1, 4, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);   // reset beats tick
        add(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        quiet(3, 0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b1, 4, 1'b0, 1'b0, 1'b0);
        quiet(4, 4, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b1, 5, 1'b0, 1'b1, 1'b0);   // tick on overdue cycle
        quiet(2, 5, 1'b0, 1'b1);

        foreach (vecs[i]) begin
            v = vecs[i];
            @(negedge clk);
            rst_n = v.rst_n;
            tick  = v.tick;
            exp_q.push_back(v);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_checks++;
            if ({period_valid, period, locked, fault, timeout} !==
                {e.pv, e.period, e.locked, e.fault, e.timeout}) begin
                n_fail++;
                $display("FAIL vec%0d: got pv=%0d period=%0d locked=%0d fault=%0d timeout=%0d, expected pv=%0d period=%0d locked=%0d fault=%0d timeout=%0d",
                         i, period_valid, period, locked, fault, timeout,
                         e.pv, e.period, e.locked, e.fault, e.timeout);
            end
        end

        // Single timeout pulse after one tick and a long silence
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        pulses   = 0;
        first_at = -1;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0);
            if (timeout) begin
                pulses++;
                if (first_at < 0) first_at = i;
            end
        end
        check("timeout_pulses", pulses, 1);
        check("timeout_cycle", first_at, 4);
        check("timeout_fault", int'(fault), 1);
        check("timeout_locked", int'(locked), 0);

`ifdef TICK_MON_STATS_EN
        step(1'b0, 1'b0);
        check("stats_min_reset", int'(min_period), 7);
        check("stats_max_reset", int'(max_period), 0);
        check("stats_err_reset", int'(err_cnt), 0);
        step(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        check("stats_min", int'(min_period), 3);
        check("stats_max", int'(max_period), 5);
        check("stats_err", int'(err_cnt), 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tick_period_monitor.md
TICK_PERIOD_MONITOR -- requirements
Module: tick_period_monitor

Interface
REQ-001 Parameter INTERNAL_CLK, default 4: system clock frequency, same units as OUTPUT_TIME_FREQ.
REQ-002 Parameter OUTPUT_TIME_FREQ, default 1: nominal tick frequency.
REQ-003 Parameter EXP_PERIOD, default INTERNAL_CLK/OUTPUT_TIME_FREQ: nominal tick interval in clk cycles.
REQ-004 Parameter TOL, default 0: allowed deviation in cycles; the in-range window is [EXP_PERIOD-TOL, EXP_PERIOD+TOL].
REQ-005 Parameter LOCK_COUNT, default 2: consecutive in-range periods required to lock.
REQ-006 Parameter CNT_W, default $clog2(EXP_PERIOD+TOL+2): counter and period width.
REQ-007 clk  input  1  single system clock, rising edge.
REQ-008 rst_n  input  1  reset, synchronous, active-low.
REQ-009 tick  input  1  one-cycle pulse from the tick generator (divider output).
REQ-010 period  output  CNT_W  last measured interval in cycles.
REQ-011 period_valid  output  1  one-cycle strobe; period updated.
REQ-012 locked  output  1  level; tick stream is stable and in range.
REQ-013 fault  output  1  level; out-of-range period or timeout seen.
REQ-014 timeout  output  1  one-cycle strobe; tick overdue.

Function
REQ-015 Counter cnt: on a tick cycle, cnt <= 1; otherwise cnt <= cnt+1, saturating at 2^CNT_W-1 with no wrap-around.
REQ-016 Measurement: on a tick cycle in MEASURE, LOCKED or FAULT, the sampled period equals cnt (ticks at cycles 0 and 4 give period 4).
REQ-017 All outputs are registered; period and period_valid appear the cycle after the tick.
REQ-018 States: IDLE, MEASURE, LOCKED, FAULT, with the state enum in the package.
REQ-019 IDLE: the first tick moves to MEASURE with no period_valid; the good-count is cleared.
REQ-020 MEASURE: an in-range period increments good-count; reaching LOCK_COUNT moves to LOCKED with locked=1.
REQ-021 MEASURE or LOCKED: an out-of-range period moves to FAULT, clears good-count, and sets fault=1 and locked=0.
REQ-022 MEASURE or LOCKED: cnt == EXP_PERIOD+TOL+1 without a tick moves to FAULT with a single timeout pulse.
REQ-023 FAULT: timeout is never re-pulsed; an in-range period moves to MEASURE with good-count=1 and fault=0.
REQ-024 A tick coincident with the timeout cycle is treated as an out-of-range period; no timeout pulse is given.
REQ-025 A saturated cnt sampled by a tick reports the saturated value, which is out of range.

Reset
REQ-026 rst_n=0 at a rising clk edge forces IDLE with cnt=0, period=0, period_valid=0, locked=0, fault=0, timeout=0 and good-count=0.
REQ-027 Reset has priority over a coincident tick; a mid-measurement reset discards the interval in progress.

Configuration
REQ-028 Macro TICK_MON_STATS_EN, when defined, adds outputs min_period [CNT_W], max_period [CNT_W] and err_cnt [8].
REQ-029 With TICK_MON_STATS_EN, min_period and max_period track measured periods (reset values 2^CNT_W-1 and 0).
REQ-030 With TICK_MON_STATS_EN, err_cnt increments on every entry into FAULT and saturates at 255.
REQ-031 Without TICK_MON_STATS_EN, these ports and their registers do not exist and the remaining behaviour is identical.

Structure
REQ-032 Package tick_mon_pkg holds the state enum typedef tick_mon_state_t and an in-range check function.
REQ-033 Sub-module tick_interval_counter implements the saturating cnt and the period capture; the FSM stays in the top module.

Verification (EXP_PERIOD=4, TOL=0, LOCK_COUNT=2)
REQ-034 Ticks at cycles 0, 4, 8 -> period_valid at cycles 5 and 9 with period=4, and locked=1 from cycle 9.
REQ-035 Locked, then a tick 3 cycles after the previous one -> period=3, fault=1, locked=0 on the next cycle.
REQ-036 Locked, then no tick for 5 cycles -> exactly one timeout pulse, fault=1, and no further timeout pulses.
REQ-037 In FAULT, ticks spaced 4, 4 -> fault=0 after the first in-range period, locked=1 after the second.
REQ-038 rst_n=0 for one cycle mid-interval with a coincident tick -> all outputs 0, IDLE, and the next tick gives no period_valid.
REQ-039 With TICK_MON_STATS_EN, periods 4, 3, 5 -> min_period=3, max_period=5, err_cnt=1.
